patch_head_classifier: RTL and testbench
========================================

Name: patch_head_classifier

Overview:
- Parametrised successor to the patch-sum classifier.
- Streams a patch-major image and sums each PATCH_SIZE×PATCH_SIZE patch into patch memory.
- Runs a signed linear head over NUM_CLASSES classes with run-time loadable weights, one MAC per cycle.
- Returns the argmax class and its score over a valid/ready result handshake; sits between the pixel DMA and the host result FIFO.

Parameters:
- IMAGE_SIZE, 28, image side in pixels; must be a multiple of PATCH_SIZE.
- PATCH_SIZE, 7, patch side in pixels.
- NUM_CLASSES, 3, number of output classes (≥2).
- PIX_W, 8, unsigned pixel width.
- W_W, 16, signed head-weight width.
- ACC_W, 40, signed score accumulator width; must be ≥ SUM_W+1+W_W+clog2(PATCHES).

Derived localparams:
- PATCHES = (IMAGE_SIZE/PATCH_SIZE)^2.
- EMBED_DIM = PATCH_SIZE^2.
- SUM_W = PIX_W+clog2(EMBED_DIM).
- CLS_W = max(1, clog2(NUM_CLASSES)).
- PIDX_W = max(1, clog2(PATCHES)).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- ready  out  1  high in IDLE; reset 1
- pixel_in  in  PIX_W  pixel, patch-major order (all pixels of patch 0, then patch 1, …)
- pixel_valid  in  1  pixel_in valid
- pixel_ready  out  1  high only in PATCH; pixel accepted when pixel_valid&&pixel_ready; reset 0
- w_wr_en  in  1  weight write strobe; honoured only in IDLE
- w_wr_class  in  CLS_W  weight class index
- w_wr_patch  in  PIDX_W  weight patch index
- w_wr_data  in  W_W  signed weight
- result_valid  out  1  result held; reset 0
- result_ready  in  1  consumer accepts result
- class_out  out  CLS_W  argmax class; reset 0
- score_out  out  ACC_W  signed winning score; reset 0

Behaviour:
- States: IDLE → PATCH → HEAD → RESULT → IDLE.
- IDLE: ready=1. start=1 → PATCH next cycle, clears pixel/patch counters and patch accumulator.
  - Weight writes: weight[c][p] updated when w_wr_en=1. Writes with out-of-range c or p, and any writes outside IDLE, are ignored.
- PATCH:
  - Each accepted pixel adds to a SUM_W-bit patch accumulator (zero-extended); this cannot overflow.
  - On the EMBED_DIM-th pixel of a patch, patch_mem[patch] = acc + pixel, and the accumulator clears.
  - After patch PATCHES-1 completes → HEAD; pixel_ready drops the following cycle.
  - start is ignored in this state.
- HEAD:
  - Iterates class c = 0..NUM_CLASSES-1, and within each class patch p = 0..PATCHES-1.
  - One MAC per cycle: score += signed({0,patch_mem[p]}) × weight[c][p].
  - After the last p of class c, compare score against best: score > best (strict, signed), or c==0, → best = score, best_cls = c. Ties therefore resolve to the lowest index.
  - The score clears for the next class.
  - After the compare for the final class → RESULT.
- Latency: result_valid rises exactly NUM_CLASSES×PATCHES+1 cycles after the clock edge accepting the last pixel (49 for defaults).
- RESULT:
  - result_valid=1; class_out and score_out are stable until result_valid&&result_ready.
  - On handshake: next cycle result_valid=0, state IDLE, ready=1.
  - start in the handshake cycle is ignored.
- Accumulator wrap: two's-complement wrap at ACC_W, with no saturation; this is unreachable given the ACC_W constraint.
- rst in any state:
  - Next cycle: IDLE, counters cleared, outputs at reset values.
  - Weight memory and patch_mem are NOT cleared; weights persist across rst.

Decomposition:
- Package classifier_pkg: state encoding enum; clog2-based width helper function; default parameter constants.
- Sub-module head_mac: signed multiply-accumulate with clear/enable and best-score/argmax register. The top FSM drives its indices.

Test Plan:
- Load weights class0=1, class1=2, class2=0 for all patches; frame of all pixels=1 → class_out=1, score_out=1568 (16×49×2).
- Weights class0=3, class1=1, class2=3; all pixels=255 → tie; class_out=0, score_out=16×12495×3=599760.
- Weights class0=-1, class1=-2, class2=0; all pixels=10 → class_out=2, score_out=0. Negative scores are checked internally via the class0 path with class2 weights=-5 → class_out=0, score_out=-7840.
- Throttle pixel_valid at 50% random and hold result_ready=0 for 5 cycles → result unchanged and valid during the hold, correct class; result_valid=1 exactly 49 cycles after the last pixel.
- Assert rst after 100 accepted pixels, then run a full frame with the same weights → correct result; weights retained without reload.
- w_wr_en pulses and start during PATCH/HEAD → weights unchanged, no second frame, result matches the golden model.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared state encoding, width helper and default parameter values for the
// patch-sum / linear-head classifier.
package classifier_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PATCH,
    S_HEAD,
    S_RESULT
  } state_t;

  localparam int DEF_IMAGE_SIZE  = 28;
  localparam int DEF_PATCH_SIZE  = 7;
  localparam int DEF_NUM_CLASSES = 3;
  localparam int DEF_PIX_W       = 8;
  localparam int DEF_W_W         = 16;
  localparam int DEF_ACC_W       = 40;

  // Index width for n entries, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/head_mac.sv
// Signed multiply-accumulate for the linear head, with a registered product
// stage and the running best-score / argmax register.
module head_mac #(
  parameter int ACC_W = 40,
  parameter int SUM_W = 14,
  parameter int W_W   = 16,
  parameter int CLS_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    issue,
  input  logic [CLS_W-1:0]        issue_cls,
  input  logic                    issue_last,
  input  logic                    issue_final,
  input  logic [SUM_W-1:0]        a,
  input  logic signed [W_W-1:0]   w,
  output logic                    done,
  output logic signed [ACC_W-1:0] best_score,
  output logic [CLS_W-1:0]        best_cls
);

  localparam int PROD_W = SUM_W + 1 + W_W;

  logic signed [SUM_W:0]      a_s;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_q;
  logic signed [ACC_W-1:0]    score;
  logic signed [ACC_W-1:0]    score_sum;
  logic                       v_q;
  logic                       last_q;
  logic                       final_q;
  logic [CLS_W-1:0]           cls_q;

  assign a_s       = {1'b0, a};
  assign prod      = a_s * w;
  assign score_sum = score + prod_q;
  assign done      = v_q && last_q && final_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q        <= 1'b0;
      last_q     <= 1'b0;
      final_q    <= 1'b0;
      cls_q      <= '0;
      prod_q     <= '0;
      score      <= '0;
      best_score <= '0;
      best_cls   <= '0;
    end else begin
      v_q <= issue;
      if (issue) begin
        prod_q  <= ACC_W'(prod);
        cls_q   <= issue_cls;
        last_q  <= issue_last;
        final_q <= issue_final;
      end
      if (clr) begin
        score <= '0;
      end else if (v_q) begin
        // Class boundary: strict compare keeps the lowest index on ties.
        if (last_q) begin
          score <= '0;
          if ((cls_q == '0) || (score_sum > best_score)) begin
            best_score <= score_sum;
            best_cls   <= cls_q;
          end
        end else begin
          score <= score_sum;
        end
      end
    end
  end

endmodule

// File: rtl/patch_head_classifier.sv
// Streams a patch-major image into per-patch sums, then runs a signed linear
// head over all classes and returns the argmax over a valid/ready handshake.
module patch_head_classifier
  import classifier_pkg::*;
#(
  parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
  parameter int PATCH_SIZE  = DEF_PATCH_SIZE,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int PIX_W       = DEF_PIX_W,
  parameter int W_W         = DEF_W_W,
  parameter int ACC_W       = DEF_ACC_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  ready,
  input  logic [PIX_W-1:0]                      pixel_in,
  input  logic                                  pixel_valid,
  output logic                                  pixel_ready,
  input  logic                                  w_wr_en,
  input  logic [width_of(NUM_CLASSES)-1:0]      w_wr_class,
  input  logic [width_of((IMAGE_SIZE/PATCH_SIZE)*(IMAGE_SIZE/PATCH_SIZE))-1:0] w_wr_patch,
  input  logic signed [W_W-1:0]                 w_wr_data,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [width_of(NUM_CLASSES)-1:0]      class_out,
  output logic signed [ACC_W-1:0]               score_out
);

  localparam int PATCHES   = (IMAGE_SIZE / PATCH_SIZE) * (IMAGE_SIZE / PATCH_SIZE);
  localparam int EMBED_DIM = PATCH_SIZE * PATCH_SIZE;
  localparam int SUM_W     = PIX_W + $clog2(EMBED_DIM);
  localparam int CLS_W     = width_of(NUM_CLASSES);
  localparam int PIDX_W    = width_of(PATCHES);
  localparam int PCNT_W    = width_of(EMBED_DIM);

  state_t state, state_next;

  logic [PCNT_W-1:0]      pix_cnt;
  logic [PIDX_W-1:0]      patch_cnt;
  logic [SUM_W-1:0]       patch_acc;
  logic [CLS_W-1:0]       head_c;
  logic [PIDX_W-1:0]      head_p;
  logic                   issue_busy;
  logic [SUM_W-1:0]       patch_mem  [PATCHES];
  logic signed [W_W-1:0]  weight_mem [NUM_CLASSES][PATCHES];

  logic pix_accept, patch_end, frame_end;
  logic head_last_p, head_last_c, mac_done, frame_start;

  assign pix_accept  = (state == S_PATCH) && pixel_valid;
  assign patch_end   = pix_accept && (pix_cnt == PCNT_W'(EMBED_DIM - 1));
  assign frame_end   = patch_end && (patch_cnt == PIDX_W'(PATCHES - 1));
  assign frame_start = (state == S_IDLE) && start;
  assign head_last_p = (head_p == PIDX_W'(PATCHES - 1));
  assign head_last_c = (head_c == CLS_W'(NUM_CLASSES - 1));

  assign ready        = (state == S_IDLE);
  assign pixel_ready  = (state == S_PATCH);
  assign result_valid = (state == S_RESULT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_PATCH;
      S_PATCH:  if (frame_end) state_next = S_HEAD;
      S_HEAD:   if (mac_done) state_next = S_RESULT;
      S_RESULT: if (result_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Pixel/patch counters and the head issue sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      patch_cnt  <= '0;
      patch_acc  <= '0;
      head_c     <= '0;
      head_p     <= '0;
      issue_busy <= 1'b0;
    end else begin
      if (frame_start) begin
        pix_cnt   <= '0;
        patch_cnt <= '0;
        patch_acc <= '0;
      end else if (patch_end) begin
        pix_cnt   <= '0;
        patch_acc <= '0;
        patch_cnt <= frame_end ? '0 : patch_cnt + 1'b1;
      end else if (pix_accept) begin
        pix_cnt   <= pix_cnt + 1'b1;
        patch_acc <= patch_acc + SUM_W'(pixel_in);
      end

      if (frame_end) begin
        issue_busy <= 1'b1;
        head_c     <= '0;
        head_p     <= '0;
      end else if (issue_busy) begin
        if (head_last_p) begin
          head_p <= '0;
          if (head_last_c) issue_busy <= 1'b0;
          else             head_c     <= head_c + 1'b1;
        end else begin
          head_p <= head_p + 1'b1;
        end
      end
    end
  end

  // Storage is deliberately left out of reset so weights survive rst.
  always_ff @(posedge clk) begin
    if (!rst && patch_end)
      patch_mem[patch_cnt] <= patch_acc + SUM_W'(pixel_in);
    if (!rst && (state == S_IDLE) && w_wr_en &&
        (int'(w_wr_class) < NUM_CLASSES) && (int'(w_wr_patch) < PATCHES))
      weight_mem[w_wr_class][w_wr_patch] <= w_wr_data;
  end

  head_mac #(
    .ACC_W (ACC_W),
    .SUM_W (SUM_W),
    .W_W   (W_W),
    .CLS_W (CLS_W)
  ) u_head_mac (
    .clk         (clk),
    .rst         (rst),
    .clr         (frame_start),
    .issue       (issue_busy),
    .issue_cls   (head_c),
    .issue_last  (head_last_p),
    .issue_final (head_last_c),
    .a           (patch_mem[head_p]),
    .w           (weight_mem[head_c][head_p]),
    .done        (mac_done),
    .best_score  (score_out),
    .best_cls    (class_out)
  );

endmodule

// File: tb/tb_patch_head_classifier.sv
// Directed bench for patch_head_classifier: table of uniform frames plus
// hand-written throttle, mid-frame reset and ignored-write sequences.
module tb_patch_head_classifier;

  localparam int PIX_W  = 8;
  localparam int W_W    = 16;
  localparam int ACC_W  = 40;
  localparam int NC     = 3;
  localparam int NP     = 16;
  localparam int ED     = 49;
  localparam int NPIX   = NP * ED;
  localparam int CLS_W  = 2;
  localparam int PIDX_W = 4;
  localparam int LAT    = NC * NP + 1;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic                    ready;
  logic [PIX_W-1:0]        pixel_in;
  logic                    pixel_valid;
  logic                    pixel_ready;
  logic                    w_wr_en;
  logic [CLS_W-1:0]        w_wr_class;
  logic [PIDX_W-1:0]       w_wr_patch;
  logic signed [W_W-1:0]   w_wr_data;
  logic                    result_valid;
  logic                    result_ready;
  logic [CLS_W-1:0]        class_out;
  logic signed [ACC_W-1:0] score_out;

  patch_head_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .w_wr_en      (w_wr_en),
    .w_wr_class   (w_wr_class),
    .w_wr_patch   (w_wr_patch),
    .w_wr_data    (w_wr_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .class_out    (class_out),
    .score_out    (score_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wm [NC][NP];
  int img [NPIX];

  typedef struct {
    int     w0, w1, w2;
    int     pix;
    int     exp_cls;
    longint exp_score;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: patch sums, per-class dot products, strict-greater argmax.
  function automatic void model(output int cls, output longint score);
    longint sums [NP];
    longint s;
    for (int p = 0; p < NP; p++) begin
      sums[p] = 0;
      for (int k = 0; k < ED; k++) sums[p] += img[p * ED + k];
    end
    cls = 0;
    score = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int p = 0; p < NP; p++) s += sums[p] * wm[c][p];
      if (c == 0 || s > score) begin
        score = s;
        cls = c;
      end
    end
  endfunction

  task automatic load_weights();
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NP; p++) begin
        @(negedge clk);
        w_wr_en    = 1'b1;
        w_wr_class = CLS_W'(c);
        w_wr_patch = PIDX_W'(p);
        w_wr_data  = W_W'(wm[c][p]);
      end
    end
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  task automatic set_uniform_weights(input int w0, input int w1, input int w2);
    for (int p = 0; p < NP; p++) begin
      wm[0][p] = w0;
      wm[1][p] = w1;
      wm[2][p] = w2;
    end
  endtask

  task automatic disturb_inputs();
    w_wr_en    = 1'($urandom_range(0, 1));
    w_wr_class = CLS_W'($urandom_range(0, 3));
    w_wr_patch = PIDX_W'($urandom_range(0, 15));
    w_wr_data  = W_W'($urandom);
    start      = 1'($urandom_range(0, 1));
  endtask

  // Driver: whole frame, latency measurement, result hold and handshake.
  task automatic run_frame(input string tag, input bit throttle, input bit disturb,
                           input int hold, input int exp_cls, input longint exp_score);
    int idx;
    int guard;
    int lat;
    bit v;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < NPIX && guard < 20000) begin
      v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_valid = v;
      pixel_in    = PIX_W'(img[idx]);
      if (disturb) disturb_inputs();
      if (v && pixel_ready) idx++;
      @(negedge clk);
      guard++;
    end
    pixel_valid = 1'b0;
    if (idx < NPIX) check({tag, "_pixels_accepted"}, idx, NPIX);
    lat = 0;
    while (!result_valid && lat < 200) begin
      if (disturb) disturb_inputs();
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_class"}, class_out, exp_cls);
    check({tag, "_score"}, longint'(score_out), exp_score);
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      if (disturb) disturb_inputs();
      @(negedge clk);
      check({tag, "_hold_valid"}, result_valid, 1);
      check({tag, "_hold_class"}, class_out, exp_cls);
      check({tag, "_hold_score"}, longint'(score_out), exp_score);
    end
    result_ready = 1'b1;
    if (disturb) begin
      start   = 1'b1;
      w_wr_en = 1'b1;
    end
    @(negedge clk);
    result_ready = 1'b0;
    start        = 1'b0;
    w_wr_en      = 1'b0;
    check({tag, "_post_valid"}, result_valid, 0);
    check({tag, "_post_ready"}, ready, 1);
  endtask

  initial begin
    int mcls;
    longint mscore;
    int acc_cnt;
    int guard;

    rst = 1'b1;
    start = 1'b0;
    pixel_in = '0;
    pixel_valid = 1'b0;
    w_wr_en = 1'b0;
    w_wr_class = '0;
    w_wr_patch = '0;
    w_wr_data = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_ready", ready, 1);
    check("reset_pixel_ready", pixel_ready, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_class", class_out, 0);
    check("reset_score", longint'(score_out), 0);

    vecs[0] = '{w0: 1,  w1: 2,  w2: 0,  pix: 1,   exp_cls: 1, exp_score: 1568};
    vecs[1] = '{w0: 3,  w1: 1,  w2: 3,  pix: 255, exp_cls: 0, exp_score: 599760};
    vecs[2] = '{w0: -1, w1: -2, w2: 0,  pix: 10,  exp_cls: 2, exp_score: 0};
    vecs[3] = '{w0: -1, w1: -2, w2: -5, pix: 10,  exp_cls: 0, exp_score: -7840};
    vecs[4] = '{w0: 0,  w1: 0,  w2: 0,  pix: 200, exp_cls: 0, exp_score: 0};

    for (int i = 0; i < 5; i++) begin
      set_uniform_weights(vecs[i].w0, vecs[i].w1, vecs[i].w2);
      load_weights();
      for (int k = 0; k < NPIX; k++) img[k] = vecs[i].pix;
      run_frame($sformatf("vec%0d", i), 1'b0, 1'b0, 0, vecs[i].exp_cls, vecs[i].exp_score);
    end

    // Patch-dependent image with throttled pixels and a held result.
    for (int p = 0; p < NP; p++) begin
      wm[0][p] = 1;
      wm[1][p] = (p == 5) ? 100 : 0;
      wm[2][p] = -1;
    end
    load_weights();
    for (int k = 0; k < NPIX; k++) img[k] = k / ED + 1;
    run_frame("throttle", 1'b1, 1'b0, 5, 1, 29400);

    // Reset after 100 accepted pixels, then a full frame without reload.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_cnt = 0;
    guard = 0;
    while (acc_cnt < 100 && guard < 1000) begin
      pixel_valid = 1'b1;
      pixel_in    = PIX_W'(acc_cnt);
      if (pixel_ready) acc_cnt++;
      @(negedge clk);
      guard++;
    end
    check("midrst_accepted", acc_cnt, 100);
    pixel_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", ready, 1);
    check("midrst_pixel_ready", pixel_ready, 0);
    check("midrst_result_valid", result_valid, 0);
    check("midrst_class", class_out, 0);
    check("midrst_score", longint'(score_out), 0);
    for (int k = 0; k < NPIX; k++) img[k] = (k * 7) % 256;
    model(mcls, mscore);
    run_frame("after_rst", 1'b0, 1'b0, 0, mcls, mscore);

    // Weight writes and start pulses outside IDLE must have no effect.
    for (int k = 0; k < NPIX; k++) img[k] = (k * 13 + 5) % 256;
    model(mcls, mscore);
    run_frame("disturb", 1'b1, 1'b1, 3, mcls, mscore);
    repeat (4) @(negedge clk);
    check("no_second_frame_ready", ready, 1);
    check("no_second_frame_pixel_ready", pixel_ready, 0);
    check("no_second_frame_valid", result_valid, 0);
    run_frame("weights_intact", 1'b0, 1'b0, 0, mcls, mscore);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
